// File: rtl/axis_sweep_pkg.sv
// Shared types and elaboration helpers for the AXIS load-sweep sequencer.
package axis_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      SETTLE,
      RUN,
      REPORT,
      DRAIN
   } state_t;

   // Width of a sum of num_tg counters of count_w bits, wide enough to never overflow.
   function automatic int sum_width(input int count_w, input int num_tg);
      return count_w + $clog2(num_tg);
   endfunction

   // Largest of three cycle counts; sizes the shared phase counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/axis_sweep_sum.sv
// Registered adder of NUM_TG packed counters; result is valid one cycle after the inputs.
module axis_sweep_sum
   import axis_sweep_pkg::*;
#(
   parameter int NUM_TG      = 4,
   parameter int COUNT_WIDTH = 32,
   parameter int SUM_W       = sum_width(COUNT_WIDTH, NUM_TG)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_TG*COUNT_WIDTH-1:0] vec_i,
   output logic [SUM_W-1:0]              sum_o
);

   logic [SUM_W-1:0] sum_d;
   logic [SUM_W-1:0] sum_q;

   // Combinational sum of all lanes, each zero-extended to the full sum width.
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < NUM_TG; i++) begin
         sum_d = sum_d + SUM_W'(vec_i[i*COUNT_WIDTH +: COUNT_WIDTH]);
      end
   end

   // Register the sum so the completion compare sees a stable value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/axis_sweep_controller.sv
// Load-sweep sequencer: for each table entry, resets the traffic harness, runs all
// generators until they finish and the global sent/recv totals agree (or a timeout
// expires), then emits one result record before moving to the next load.
module axis_sweep_controller
   import axis_sweep_pkg::*;
#(
   parameter int NUM_TG         = 4,
   parameter int COUNT_WIDTH    = 32,
   parameter int LOAD_WIDTH     = 16,
   parameter int NUM_LOADS      = 14,
   parameter int RST_CYCLES     = 6,
   parameter int SETTLE_CYCLES  = 5,
   parameter int MIN_RUN_CYCLES = 6,
   parameter int DRAIN_CYCLES   = 3,
   parameter int TIMEOUT_WIDTH  = 31
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              go,
   input  logic [NUM_LOADS*LOAD_WIDTH-1:0]   load_table,
   output logic                              harness_rst_n,
   output logic [LOAD_WIDTH-1:0]             load,
   output logic [NUM_TG-1:0]                 start,
   input  logic [NUM_TG-1:0]                 done,
   input  logic [NUM_TG-1:0]                 error,
   input  logic [NUM_TG*COUNT_WIDTH-1:0]     total_sent,
   input  logic [NUM_TG*COUNT_WIDTH-1:0]     total_recv,
   output logic                              busy,
   output logic                              point_valid,
   output logic [$clog2(NUM_LOADS):0]        point_idx,
   output logic                              point_timeout,
   output logic                              point_error,
   output logic [TIMEOUT_WIDTH:0]            point_cycles,
   output logic                              sweep_done
);

   localparam int SUM_W = sum_width(COUNT_WIDTH, NUM_TG);
   localparam int IDX_W = $clog2(NUM_LOADS) + 1;
   localparam int RUN_W = TIMEOUT_WIDTH + 1;
   localparam int CNT_W = $clog2(max3(RST_CYCLES, SETTLE_CYCLES, DRAIN_CYCLES) + 1);

   localparam logic [RUN_W-1:0] RUN_LAST    = {1'b0, {TIMEOUT_WIDTH{1'b1}}};
   localparam logic [RUN_W-1:0] RUN_MIN     = RUN_W'(MIN_RUN_CYCLES);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_LOADS - 1);

   state_t                 state_q,     state_d;
   logic [CNT_W-1:0]       cnt_q,       cnt_d;
   logic [RUN_W-1:0]       run_cnt_q,   run_cnt_d;
   logic [IDX_W-1:0]       idx_q,       idx_d;
   logic [LOAD_WIDTH-1:0]  load_q,      load_d;
   logic                   hrst_n_q,    hrst_n_d;
   logic [NUM_TG-1:0]      start_q,     start_d;
   logic [NUM_TG-1:0]      done_seen_q, done_seen_d;
   logic                   busy_q,      busy_d;
   logic                   pvalid_q,    pvalid_d;
   logic [IDX_W-1:0]       pidx_q,      pidx_d;
   logic                   ptimeout_q,  ptimeout_d;
   logic                   perror_q,    perror_d;
   logic [RUN_W-1:0]       pcycles_q,   pcycles_d;
   logic                   sdone_q,     sdone_d;

   logic [SUM_W-1:0]       sum_sent_q;
   logic [SUM_W-1:0]       sum_recv_q;
   logic [IDX_W-1:0]       idx_next;

   axis_sweep_sum #(
      .NUM_TG      (NUM_TG),
      .COUNT_WIDTH (COUNT_WIDTH),
      .SUM_W       (SUM_W)
   ) u_sum_sent (
      .clk   (clk),
      .rst_n (rst_n),
      .vec_i (total_sent),
      .sum_o (sum_sent_q)
   );

   axis_sweep_sum #(
      .NUM_TG      (NUM_TG),
      .COUNT_WIDTH (COUNT_WIDTH),
      .SUM_W       (SUM_W)
   ) u_sum_recv (
      .clk   (clk),
      .rst_n (rst_n),
      .vec_i (total_recv),
      .sum_o (sum_recv_q)
   );

   assign idx_next = idx_q + 1'b1;

   // Next-state and register update logic; every state reuses the single phase counter.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      run_cnt_d   = run_cnt_q;
      idx_d       = idx_q;
      load_d      = load_q;
      hrst_n_d    = hrst_n_q;
      start_d     = start_q;
      done_seen_d = done_seen_q;
      busy_d      = busy_q;
      pvalid_d    = 1'b0;
      pidx_d      = pidx_q;
      ptimeout_d  = ptimeout_q;
      perror_d    = perror_q;
      pcycles_d   = pcycles_q;
      sdone_d     = 1'b0;

      case (state_q)
         IDLE: begin
            hrst_n_d = 1'b0;
            // The cycle that reports sweep_done still belongs to the finished sweep.
            if (go && !sdone_q) begin
               idx_d       = '0;
               load_d      = load_table[0 +: LOAD_WIDTH];
               busy_d      = 1'b1;
               cnt_d       = '0;
               done_seen_d = '0;
               state_d     = RESET;
            end
         end

         RESET: begin
            hrst_n_d = 1'b0;
            if (cnt_q == RST_LAST) begin
               cnt_d    = '0;
               hrst_n_d = 1'b1;
               state_d  = SETTLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d     = '0;
               start_d   = '1;
               run_cnt_d = '0;
               state_d   = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RUN: begin
            done_seen_d = done_seen_q | done;
            start_d     = start_q & ~done_seen_q;
            run_cnt_d   = run_cnt_q + 1'b1;
            // Timeout is tested first so it wins over a completion in the same cycle.
            if (run_cnt_q == RUN_LAST) begin
               ptimeout_d = 1'b1;
               state_d    = REPORT;
            end else if ((run_cnt_q >= RUN_MIN) && (&done_seen_q) &&
                         (sum_sent_q == sum_recv_q)) begin
               ptimeout_d = 1'b0;
               state_d    = REPORT;
            end
            if (state_d == REPORT) begin
               start_d   = '0;
               run_cnt_d = run_cnt_q;
               pvalid_d  = 1'b1;
               pidx_d    = idx_q;
               perror_d  = |error;
               pcycles_d = run_cnt_q;
            end
         end

         REPORT: begin
            start_d = '0;
            cnt_d   = '0;
            state_d = DRAIN;
         end

         DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               cnt_d    = '0;
               hrst_n_d = 1'b0;
               if (idx_q == IDX_LAST) begin
                  busy_d  = 1'b0;
                  sdone_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  // Load only changes here, while the harness is going back into reset.
                  idx_d       = idx_next;
                  load_d      = load_table[int'(idx_next)*LOAD_WIDTH +: LOAD_WIDTH];
                  done_seen_d = '0;
                  state_d     = RESET;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any sweep in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         run_cnt_q   <= '0;
         idx_q       <= '0;
         load_q      <= '0;
         hrst_n_q    <= 1'b0;
         start_q     <= '0;
         done_seen_q <= '0;
         busy_q      <= 1'b0;
         pvalid_q    <= 1'b0;
         pidx_q      <= '0;
         ptimeout_q  <= 1'b0;
         perror_q    <= 1'b0;
         pcycles_q   <= '0;
         sdone_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         run_cnt_q   <= run_cnt_d;
         idx_q       <= idx_d;
         load_q      <= load_d;
         hrst_n_q    <= hrst_n_d;
         start_q     <= start_d;
         done_seen_q <= done_seen_d;
         busy_q      <= busy_d;
         pvalid_q    <= pvalid_d;
         pidx_q      <= pidx_d;
         ptimeout_q  <= ptimeout_d;
         perror_q    <= perror_d;
         pcycles_q   <= pcycles_d;
         sdone_q     <= sdone_d;
      end
   end

   assign harness_rst_n = hrst_n_q;
   assign load          = load_q;
   assign start         = start_q;
   assign busy          = busy_q;
   assign point_valid   = pvalid_q;
   assign point_idx     = pidx_q;
   assign point_timeout = ptimeout_q;
   assign point_error   = perror_q;
   assign point_cycles  = pcycles_q;
   assign sweep_done    = sdone_q;

endmodule

// File: tb/tb_axis_sweep_controller.sv
// Directed bench for axis_sweep_controller: two-point sweeps driven from a table of
// per-point traffic scenarios, plus reset and abort sequences.
module tb_axis_sweep_controller;

   localparam int NTG = 4;
   localparam int CW  = 32;
   localparam int LW  = 16;
   localparam int NL  = 2;
   localparam int TW  = 6;
   localparam logic [7:0] NEVER = 8'd255;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 go;
   logic [NL*LW-1:0]     load_table;
   logic                 harness_rst_n;
   logic [LW-1:0]        load;
   logic [NTG-1:0]       start;
   logic [NTG-1:0]       done;
   logic [NTG-1:0]       error;
   logic [NTG*CW-1:0]    total_sent;
   logic [NTG*CW-1:0]    total_recv;
   logic                 busy;
   logic                 point_valid;
   logic [1:0]           point_idx;
   logic                 point_timeout;
   logic                 point_error;
   logic [TW:0]          point_cycles;
   logic                 sweep_done;

   int checks = 0;
   int errors = 0;

   // One sweep point: per-TG done cycle (8 bits each), done as single pulse,
   // cycle at which recv lane 3 catches up, recv never catching up, error inputs,
   // and the expected result record.
   typedef struct packed {
      logic [31:0] d;
      logic        pulse;
      logic [7:0]  fix;
      logic        never;
      logic [3:0]  err;
      logic        exp_to;
      logic        exp_err;
      logic [7:0]  exp_cyc;
   } vec_t;

   vec_t tbl [8];
   logic [LW-1:0] loads [2];

   axis_sweep_controller #(
      .NUM_TG         (NTG),
      .COUNT_WIDTH    (CW),
      .LOAD_WIDTH     (LW),
      .NUM_LOADS      (NL),
      .RST_CYCLES     (6),
      .SETTLE_CYCLES  (5),
      .MIN_RUN_CYCLES (6),
      .DRAIN_CYCLES   (3),
      .TIMEOUT_WIDTH  (TW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .go            (go),
      .load_table    (load_table),
      .harness_rst_n (harness_rst_n),
      .load          (load),
      .start         (start),
      .done          (done),
      .error         (error),
      .total_sent    (total_sent),
      .total_recv    (total_recv),
      .busy          (busy),
      .point_valid   (point_valid),
      .point_idx     (point_idx),
      .point_timeout (point_timeout),
      .point_error   (point_error),
      .point_cycles  (point_cycles),
      .sweep_done    (sweep_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      done       = '0;
      error      = '0;
      total_sent = '0;
      total_recv = '0;
      go         = 1'b0;
   endtask

   // Bench model of the TG/checker array during run cycle k.
   task automatic drive(input vec_t v, input int k);
      for (int i = 0; i < NTG; i++) begin
         int di;
         di = int'(v.d[i*8 +: 8]);
         done[i] = v.pulse ? (k == di) : (k >= di);
      end
      error      = v.err;
      total_sent = {NTG{32'd100}};
      total_recv = {32'((v.never || k < int'(v.fix)) ? 99 : 100), {3{32'd100}}};
      go         = (k == 3);
   endtask

   // Runs one point from its reset phase to the cycle after its report.
   task automatic run_point(input int p, input int idx);
      vec_t v;
      int   n;
      int   lows;
      int   highs;
      int   k;
      bit   seen;
      logic [NTG-1:0] exp_start;
      v = tbl[p];
      n = 0;
      while (harness_rst_n && n < 100) begin
         @(negedge clk);
         n++;
      end
      lows = 0;
      while (!harness_rst_n && lows < 100) begin
         lows++;
         @(negedge clk);
      end
      highs = 0;
      while (start !== 4'hF && highs < 100) begin
         highs++;
         @(negedge clk);
      end
      chk($sformatf("p%0d_rst_low_cycles", p), lows, 6);
      chk($sformatf("p%0d_settle_cycles", p), highs, 5);
      chk($sformatf("p%0d_load", p), load, loads[idx]);
      chk($sformatf("p%0d_busy", p), busy, 1'b1);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 200) begin
         if (point_valid) begin
            seen = 1'b1;
         end else begin
            for (int i = 0; i < NTG; i++) exp_start[i] = (k < int'(v.d[i*8 +: 8]) + 2);
            chk($sformatf("p%0d_start_k%0d", p, k), start, exp_start);
            drive(v, k);
            @(negedge clk);
            k++;
         end
      end
      chk($sformatf("p%0d_report_seen", p), seen, 1'b1);
      chk($sformatf("p%0d_report_latency", p), k, int'(v.exp_cyc) + 1);
      chk($sformatf("p%0d_point_idx", p), point_idx, idx);
      chk($sformatf("p%0d_point_timeout", p), point_timeout, v.exp_to);
      chk($sformatf("p%0d_point_error", p), point_error, v.exp_err);
      chk($sformatf("p%0d_point_cycles", p), point_cycles, v.exp_cyc);
      chk($sformatf("p%0d_start_clear", p), start, 4'h0);
      clear_inputs();
      @(negedge clk);
      chk($sformatf("p%0d_valid_one_cycle", p), point_valid, 1'b0);
      chk($sformatf("p%0d_drain_harness", p), harness_rst_n, 1'b1);
   endtask

   // Two-point sweep starting at table entry p0, including the end-of-sweep handshake.
   task automatic do_sweep(input int p0);
      int n;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      run_point(p0, 0);
      run_point(p0 + 1, 1);
      n = 0;
      while (!sweep_done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("s%0d_sweep_done_delay", p0), n, 3);
      chk($sformatf("s%0d_busy_low", p0), busy, 1'b0);
      chk($sformatf("s%0d_harness_low", p0), harness_rst_n, 1'b0);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      chk($sformatf("s%0d_no_pulse_repeat", p0), sweep_done, 1'b0);
      @(negedge clk);
      chk($sformatf("s%0d_go_ignored_busy", p0), busy, 1'b0);
      chk($sformatf("s%0d_go_ignored_harness", p0), harness_rst_n, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int pvc;
      //          d (tg3..tg0)               pulse fix    never err    to    err   cyc
      tbl[0] = '{32'h140E0C0A,              1'b0, 8'd0,  1'b0, 4'h0, 1'b0, 1'b0, 8'd21};
      tbl[1] = '{32'h140E0C0A,              1'b0, 8'd0,  1'b0, 4'h4, 1'b0, 1'b1, 8'd21};
      tbl[2] = '{32'h05050505,              1'b0, 8'd0,  1'b1, 4'h0, 1'b1, 1'b0, 8'd63};
      tbl[3] = '{32'h1413120F,              1'b0, 8'd50, 1'b0, 4'h0, 1'b0, 1'b0, 8'd51};
      tbl[4] = '{32'h00000000,              1'b1, 8'd0,  1'b0, 4'h0, 1'b0, 1'b0, 8'd6};
      tbl[5] = '{{8'd8, NEVER, 8'd40, 8'd3}, 1'b0, 8'd0,  1'b0, 4'h8, 1'b1, 1'b1, 8'd63};
      tbl[6] = '{32'h3E3E3E3E,              1'b0, 8'd0,  1'b0, 4'h0, 1'b1, 1'b0, 8'd63};
      tbl[7] = '{32'h3D3D3D3D,              1'b0, 8'd0,  1'b0, 4'h0, 1'b0, 1'b0, 8'd62};
      loads[0]   = 16'h1999;
      loads[1]   = 16'h3333;
      load_table = {loads[1], loads[0]};

      rst_n = 1'b0;
      clear_inputs();
      repeat (3) @(negedge clk);
      chk("rst_harness", harness_rst_n, 1'b0);
      chk("rst_load", load, 16'h0);
      chk("rst_start", start, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_point_valid", point_valid, 1'b0);
      chk("rst_sweep_done", sweep_done, 1'b0);
      chk("rst_results", {point_idx, point_timeout, point_error, point_cycles}, '0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 1'b0);

      // Abort a sweep mid-run with an asynchronous reset.
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n = 0;
      while (start !== 4'hF && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("abort_start_seen", start, 4'hF);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_harness", harness_rst_n, 1'b0);
      chk("abort_start", start, 4'h0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_load", load, 16'h0);
      chk("abort_point_valid", point_valid, 1'b0);
      pvc = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (c == 2) rst_n = 1'b1;
         if (point_valid) pvc++;
      end
      chk("abort_no_report", pvc, 0);

      do_sweep(0);
      do_sweep(2);
      do_sweep(4);
      do_sweep(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
